// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: load-use interlock via a shifting load tracker,
// jump flush, and a mul/div busy FSM with a watchdog timeout.
module hazard_sched #(
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rd_we_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_is_load_i,
  input  logic        id_is_muldiv_i,
  input  logic        ex_jump_i,
  input  logic        md_done_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic        md_start_o,
  output logic        md_busy_o,
  output logic        md_err_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [LOAD_LAT-1:0] trk_valid_q;
  logic [4:0]          trk_rd_q [LOAD_LAT];
  logic [7:0]          busy_cnt_q;
  logic [31:0]         stall_cnt_q;
  logic                hazard;
  logic                issue;
  logic                push_valid;

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < LOAD_LAT; i++) begin
      if (trk_valid_q[i] && (trk_rd_q[i] != '0) &&
          ((trk_rd_q[i] == id_rs1_addr_i) || (trk_rd_q[i] == id_rs2_addr_i)))
        hazard = 1'b1;
    end
  end

  // All 1-bit outputs are gated by rst so they read 0 the moment reset rises.
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    bubble_o   = 1'b0;
    flush_o    = 1'b0;
    md_start_o = 1'b0;
    md_busy_o  = 1'b0;
    md_err_o   = 1'b0;
    issue      = 1'b0;
    if (!rst) begin
      if (ex_jump_i) begin
        flush_o = 1'b1;
      end else if (state_q == BUSY || hazard) begin
        stall_o  = 1'b1;
        bubble_o = 1'b1;
      end else begin
        issue = id_valid_i;
      end
      md_start_o = issue & id_is_muldiv_i;
      md_busy_o  = (state_q == BUSY);
      case (state_q)
        IDLE: if (md_start_o) state_d = BUSY;
        BUSY: begin
          if (md_done_i) begin
            state_d = IDLE;
          end else if (busy_cnt_q == 8'(MD_TIMEOUT - 1)) begin
            md_err_o = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_valid  = issue & id_is_load_i & id_rd_we_i & (id_rd_addr_i != '0);
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      trk_valid_q <= '0;
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = LOAD_LAT - 1; i > 0; i--)
        trk_valid_q[i] <= trk_valid_q[i-1];
      trk_valid_q[0] <= push_valid;
      busy_cnt_q     <= (state_q == BUSY) ? busy_cnt_q + 8'd1 : '0;
      if (stall_o)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // Destination fields are only meaningful alongside their valid bit.
  always_ff @(posedge clk) begin
    for (int unsigned i = LOAD_LAT - 1; i > 0; i--)
      trk_rd_q[i] <= trk_rd_q[i-1];
    trk_rd_q[0] <= push_valid ? id_rd_addr_i : '0;
  end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed literal scenarios plus randomized traffic
// compared every cycle against a cycle-indexed behavioural model.
module tb_hazard_sched;
  localparam int unsigned LL = 2;
  localparam int unsigned MT = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        id_valid = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0, id_is_muldiv = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        ex_jump = 1'b0, md_done = 1'b0;
  logic        stall_o, bubble_o, flush_o, md_start_o, md_busy_o, md_err_o;
  logic [31:0] stall_cnt_o;

  hazard_sched #(.LOAD_LAT(LL), .MD_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rd_we_i(id_rd_we),
    .id_rd_addr_i(rd), .id_is_load_i(id_is_load), .id_is_muldiv_i(id_is_muldiv),
    .ex_jump_i(ex_jump), .md_done_i(md_done),
    .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .md_start_o(md_start_o), .md_busy_o(md_busy_o), .md_err_o(md_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a register is pending for LL cycles after the cycle its load issued.
  int          cyc = 0;
  int          load_cyc [32];
  bit          m_busy = 1'b0;
  int          m_idx = 0;
  logic [31:0] m_stall_cnt = '0;

  typedef struct packed {
    logic stall; logic flush; logic start; logic busy; logic err; logic issue;
  } exp_t;
  exp_t e_cmp, e_upd;

  function automatic bit pending(input logic [4:0] r);
    return (r != 5'd0) && ((cyc - load_cyc[r]) <= int'(LL));
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   hz;
    hz      = pending(rs1) || pending(rs2);
    e.flush = ex_jump;
    e.busy  = m_busy;
    e.stall = !ex_jump && (m_busy || hz);
    e.issue = id_valid && !ex_jump && !m_busy && !hz;
    e.start = e.issue && id_is_muldiv;
    e.err   = m_busy && !md_done && (m_idx == int'(MT) - 1);
    return e;
  endfunction

  task automatic model_reset();
    foreach (load_cyc[i]) load_cyc[i] = -100;
    m_busy      = 1'b0;
    m_idx       = 0;
    m_stall_cnt = '0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (rst) model_reset();
    e_cmp = rst ? exp_t'(0) : predict();
    check("stall",     stall_o,     e_cmp.stall);
    check("bubble",    bubble_o,    e_cmp.stall);
    check("flush",     flush_o,     e_cmp.flush);
    check("md_start",  md_start_o,  e_cmp.start);
    check("md_busy",   md_busy_o,   e_cmp.busy);
    check("md_err",    md_err_o,    e_cmp.err);
    check("stall_cnt", stall_cnt_o, m_stall_cnt);
  end

  always @(posedge clk) begin
    if (!rst) begin
      e_upd = predict();
      if (e_upd.stall) m_stall_cnt = m_stall_cnt + 32'd1;
      if (e_upd.issue && id_is_load && id_rd_we && rd != 5'd0) load_cyc[rd] = cyc;
      if (m_busy) begin
        if (md_done || e_upd.err) m_busy = 1'b0;
        else m_idx++;
      end else if (e_upd.start) begin
        m_busy = 1'b1;
        m_idx  = 0;
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_valid = 0; rs1 = '0; rs2 = '0; id_rd_we = 0; rd = '0;
    id_is_load = 0; id_is_muldiv = 0; ex_jump = 0; md_done = 0;
  endtask

  task automatic drive(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] d, input logic ld, input logic md);
    id_valid = v; rs1 = a1; rs2 = a2; id_rd_we = we; rd = d;
    id_is_load = ld; id_is_muldiv = md;
  endtask

  initial begin
    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #2 check("rst_stall_cnt", stall_cnt_o, 32'd0);
    check("rst_busy", md_busy_o, 0);
    step();

    // load x5 then dependent add
    drive(1, 0, 0, 1, 5, 1, 0); #2 check("lu_load_nostall", stall_o, 0); step();
    drive(1, 5, 1, 1, 6, 0, 0); #2 check("lu_stall1", stall_o, 1); check("lu_bubble1", bubble_o, 1); step();
    #2 check("lu_stall2", stall_o, 1); check("lu_bubble2", bubble_o, 1); step();
    #2 check("lu_issue", stall_o, 0); check("lu_cnt", stall_cnt_o, 32'd2); step();

    // load x0 never interlocks
    drive(1, 0, 0, 1, 0, 1, 0); step();
    drive(1, 0, 3, 1, 7, 0, 0); #2 check("x0_nostall", stall_o, 0); step();

    // mul, done in the 5th busy cycle
    drive(1, 1, 2, 1, 7, 0, 1); #2 check("mul_start", md_start_o, 1); check("mul_issue_nostall", stall_o, 0); step();
    drive(1, 3, 4, 1, 8, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      md_done = (k == 5);
      #2 check("mul_busy_stall", stall_o, 1); check("mul_busy", md_busy_o, 1);
      check("mul_start_once", md_start_o, 0);
      step();
    end
    md_done = 0;
    #2 check("mul_idle", md_busy_o, 0); check("mul_idle_nostall", stall_o, 0);
    check("mul_cnt", stall_cnt_o, 32'd7); step();

    // jump coincident with a load-use hazard; the jumped load x8 must not be tracked
    drive(1, 0, 0, 1, 5, 1, 0); step();
    drive(1, 5, 0, 1, 8, 1, 0); ex_jump = 1;
    #2 check("jmp_flush", flush_o, 1); check("jmp_nostall", stall_o, 0); check("jmp_nobubble", bubble_o, 0); step();
    ex_jump = 0; drive(1, 8, 0, 1, 9, 0, 0);
    #2 check("jmp_nopush", stall_o, 0); check("jmp_flush_off", flush_o, 0); step();

    // watchdog with md_done never asserted
    drive(1, 1, 2, 1, 10, 0, 1); #2 check("to_start", md_start_o, 1); step();
    idle_in();
    for (int k = 1; k <= int'(MT); k++) begin
      #2 check("to_err", md_err_o, (k == int'(MT)) ? 1'b1 : 1'b0); check("to_busy", md_busy_o, 1);
      step();
    end
    #2 check("to_idle", md_busy_o, 0); check("to_err_off", md_err_o, 0); check("to_nostall", stall_o, 0); step();

    // asynchronous reset mid-BUSY with x9 pending
    drive(1, 0, 0, 1, 9, 1, 0); step();
    drive(1, 1, 2, 1, 11, 0, 1); step();
    idle_in();
    #2 check("rb_busy", md_busy_o, 1);
    rst = 1;
    #1 check("rb_busy_clr", md_busy_o, 0); check("rb_stall_clr", stall_o, 0);
    check("rb_cnt_clr", stall_cnt_o, 32'd0); check("rb_err", md_err_o, 0);
    step();
    rst = 0; drive(1, 9, 0, 1, 12, 0, 0);
    #2 check("rb_nohazard", stall_o, 0); step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_valid     = ($urandom_range(0, 9) < 8);
      rs1          = 5'($urandom_range(0, 7));
      rs2          = 5'($urandom_range(0, 7));
      rd           = 5'($urandom_range(0, 7));
      id_rd_we     = ($urandom_range(0, 9) < 8);
      id_is_load   = ($urandom_range(0, 9) < 3);
      id_is_muldiv = !id_is_load && ($urandom_range(0, 9) < 2);
      ex_jump      = ($urandom_range(0, 9) == 0);
      md_done      = ($urandom_range(0, 9) < 2);
      rst          = ($urandom_range(0, 199) == 0);
      step();
    end
    idle_in();
    rst = 0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
